des_byte_packer: RTL
====================

Name: des_byte_packer

Overview:
- Upstream stage of DES_Enc. Accepts a byte stream with message framing and packs it into 64-bit DES blocks.
- Drives DES_Enc's plain/plain_en/key inputs directly; one block per cycle maximum, matching the fully pipelined encryptor.
- Handles short final blocks by padding and holds the key stable per message.

Parameters:
- PAD_BYTE, 8'h00, fill value for unused bytes of a short final block when padding is compiled out.
- CNT_W, 32, width of the emitted-block counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- din  in  8  input byte.
- din_valid  in  1  din is valid this cycle.
- din_last  in  1  din is the final byte of the message; qualified by din_valid.
- din_ready  out  1  packer accepts din this cycle.
- key_in  in  64  key for the next message.
- key_load  in  1  latch key_in; honoured only in IDLE.
- clr  in  1  synchronous clear of blk_cnt and key_err.
- plain  out  64  block to DES_Enc.
- plain_en  out  1  one-cycle strobe; plain is valid.
- key  out  64  key to DES_Enc; stable for a whole message.
- blk_cnt  out  CNT_W  blocks emitted since reset or clr; saturates at all-ones.
- busy  out  1  state != IDLE.
- key_err  out  1  sticky flag: key_load was seen outside IDLE.

Behaviour:
- Reset (async, rstn=0): plain=0, plain_en=0, key=0, blk_cnt=0, busy=0, key_err=0, din_ready=1, byte index idx=0, state=IDLE.
- Accept: a byte transfers when din_valid && din_ready. Big-endian packing: the first byte of a block lands in plain[63:56], the eighth in plain[7:0]. The block is built in a 64-bit shift register sr.
- States:
  - IDLE: no bytes of the current message held.
  - FILL: 1 to 7 bytes of the current message held, or a block boundary reached mid-message.
  - PAD: extra padding block pending; only reachable when padding is compiled in.
- Transitions:
  - IDLE -> FILL on an accepted byte with din_last=0.
  - FILL stays in FILL while bytes continue with din_last=0.
  - Any accepted byte with din_last=1 -> IDLE, or -> PAD (see Optional Feature).
- Full block: on the accepted byte with idx==7, the next cycle has plain={sr[55:0],din} and plain_en=1; idx wraps to 0. Latency from the eighth byte to plain_en is 1 cycle. Back-to-back bytes therefore give one block every 8 cycles.
- Short last block (din_last with idx<7, n=idx+1 bytes held): the next cycle emits plain with the n data bytes in the top positions and the remaining 8-n bytes filled per Optional Feature. plain_en=1; idx=0; state=IDLE.
- plain_en is high for exactly 1 cycle per block. plain holds its value until the next block.
- din_ready=0 only in PAD, for exactly 1 cycle; otherwise 1.
- key_load in IDLE with no byte accepted in the same cycle: key<=key_in on the next edge. key_load together with an accepted first byte in IDLE: key is loaded and applies to that message.
- key_load in FILL or PAD: ignored and key_err<=1.
- blk_cnt increments on every plain_en cycle and saturates at all-ones. If clr and plain_en occur in the same cycle, clr wins and blk_cnt becomes 0.
- din_valid with din_last while in PAD cannot occur, because din_ready=0 there.
- Reset asserted mid-message discards partial data; no plain_en is generated for it.

Optional Feature:
- Macro DES_PACK_PKCS5_PAD_EN.
- Defined: PKCS#5 padding.
  - Short last block: each of the 8-n fill bytes equals 8-n.
  - A last byte that completes a block (idx==7): the data block is emitted, then state=PAD. The next cycle after that emits 64'h0808080808080808 with plain_en=1 and din_ready=0, then returns to IDLE.
- Undefined: short-block fill bytes equal PAD_BYTE. A full last block emits only the data block and goes straight to IDLE; PAD state is not synthesised.

Test Plan:
- Reset, key_load with key_in=64'h133457799BBCDFF1, then bytes 01 23 45 67 89 AB CD EF (last on EF) -> key=64'h133457799BBCDFF1; one plain_en with plain=64'h0123456789ABCDEF, 1 cycle after EF. With padding defined, the following cycle gives plain=64'h0808080808080808 and blk_cnt=2; without it, blk_cnt=1.
- Bytes AA BB CC with last on CC -> plain=64'hAABBCC0505050505 (padding defined) or 64'hAABBCC0000000000 (undefined, PAD_BYTE=0); busy returns to 0.
- 16 contiguous bytes 00..0F, last on 0F, padding undefined -> two plain_en pulses 8 cycles apart: 64'h0001020304050607 and 64'h08090A0B0C0D0E0F.
- key_load with key_in=64'hFFFF... after 3 bytes of a message -> key unchanged and key_err=1; clr -> key_err=0 and blk_cnt=0.
- 5 bytes accepted, then rstn pulsed low -> no plain_en; all outputs at reset values; a subsequent message packs from idx=0.
- Force blk_cnt near saturation (CNT_W=4, 16 blocks) -> blk_cnt holds at 4'hF.

Source files
------------

// File: rtl/des_byte_packer_if.sv
// Byte-packer bus bundle: upstream byte stream, key/clear controls and the
// block/key outputs that feed DES_Enc.
//   master : byte source / controller (drives din*, key_in, key_load, clr)
//   slave  : des_byte_packer (drives din_ready, plain*, key, blk_cnt, busy, key_err)
interface des_byte_packer_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [7:0]       din;
  logic             din_valid;
  logic             din_last;
  logic             din_ready;
  logic [63:0]      key_in;
  logic             key_load;
  logic             clr;
  logic [63:0]      plain;
  logic             plain_en;
  logic [63:0]      key;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy;
  logic             key_err;

  modport master (
    output din, din_valid, din_last, key_in, key_load, clr,
    input  din_ready, plain, plain_en, key, blk_cnt, busy, key_err
  );

  modport slave (
    input  din, din_valid, din_last, key_in, key_load, clr,
    output din_ready, plain, plain_en, key, blk_cnt, busy, key_err
  );
endinterface

// File: rtl/des_byte_packer.sv
// Packs a framed byte stream into big-endian 64-bit blocks for DES_Enc.
// The first byte of a block lands in plain[63:56]. A short final block is
// filled with PAD_BYTE, or with PKCS#5 padding when DES_PACK_PKCS5_PAD_EN is
// defined; in that build a message ending exactly on a block boundary is
// followed by one extra 0x08 block (PAD state, din_ready low).
// Ports:
//   clk    : clock
//   rstn   : asynchronous active-low reset
//   bus_io : des_byte_packer_if.slave (byte input, key control, block output,
//            blk_cnt saturating block counter, busy, sticky key_err)
module des_byte_packer #(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 32
) (
  input logic                clk,
  input logic                rstn,
  des_byte_packer_if.slave   bus_io
);

`ifdef DES_PACK_PKCS5_PAD_EN
  typedef enum logic [1:0] {StIdle, StFill, StPad} state_e;
`else
  typedef enum logic {StIdle, StFill} state_e;
`endif

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      sr_q, sr_d;
  logic [63:0]      plain_q, plain_d;
  logic             plain_en_q, plain_en_d;
  logic [63:0]      key_q, key_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             key_err_q, key_err_d;

  logic        din_ready;
  logic        accept;
  logic [63:0] data;
  logic [63:0] block;
  logic [7:0]  fill;

`ifdef DES_PACK_PKCS5_PAD_EN
  assign din_ready = (state_q != StPad);
  assign fill      = {5'b0, ~idx_q};  // 8-n with n = idx+1
`else
  assign din_ready = 1'b1;
  assign fill      = PAD_BYTE;
`endif

  assign accept = bus_io.din_valid && din_ready;
  assign data   = {sr_q[55:0], bus_io.din};

  // Left-align the n = idx+1 held bytes, then fill the 7-idx low bytes.
  always_comb begin
    block = data << {~idx_q, 3'b000};
    for (int b = 0; b < 8; b++) begin
      if (3'(b) < ~idx_q) block[8*b +: 8] = fill;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sr_d       = sr_q;
    plain_d    = plain_q;
    plain_en_d = 1'b0;
    key_d      = key_q;
    key_err_d  = key_err_q;
    blk_cnt_d  = blk_cnt_q;

`ifdef DES_PACK_PKCS5_PAD_EN
    if (state_q == StPad) begin
      plain_d    = {8{8'h08}};
      plain_en_d = 1'b1;
      state_d    = StIdle;
    end else
`endif
    if (accept) begin
      if (bus_io.din_last || idx_q == 3'd7) begin
        plain_d    = block;
        plain_en_d = 1'b1;
        idx_d      = 3'd0;
        if (!bus_io.din_last) begin
          state_d = StFill;
`ifdef DES_PACK_PKCS5_PAD_EN
        end else if (idx_q == 3'd7) begin
          state_d = StPad;
`endif
        end else begin
          state_d = StIdle;
        end
      end else begin
        sr_d    = data;
        idx_d   = idx_q + 3'd1;
        state_d = StFill;
      end
    end

    // Key only changes between messages; a load attempt mid-message is flagged.
    if (bus_io.key_load) begin
      if (state_q == StIdle) key_d = bus_io.key_in;
      else                   key_err_d = 1'b1;
    end

    if (plain_en_d && (blk_cnt_q != {CNT_W{1'b1}})) blk_cnt_d = blk_cnt_q + CNT_W'(1);

    if (bus_io.clr) begin
      blk_cnt_d = '0;
      key_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      sr_q       <= '0;
      plain_q    <= '0;
      plain_en_q <= 1'b0;
      key_q      <= '0;
      blk_cnt_q  <= '0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sr_q       <= sr_d;
      plain_q    <= plain_d;
      plain_en_q <= plain_en_d;
      key_q      <= key_d;
      blk_cnt_q  <= blk_cnt_d;
      key_err_q  <= key_err_d;
    end
  end

  assign bus_io.din_ready = din_ready;
  assign bus_io.plain     = plain_q;
  assign bus_io.plain_en  = plain_en_q;
  assign bus_io.key       = key_q;
  assign bus_io.blk_cnt   = blk_cnt_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.key_err   = key_err_q;

endmodule
